// File: rtl/aes_128_pkg.sv
// Shared constants for the AES-128 key schedule: S-box, round constants,
// round/word sizes and the per-round word expansion helpers.
package aes_128_pkg;

   localparam logic [3:0] NR     = 4'd10;
   localparam int         NK     = 4;
   localparam int         WORD_W = 32;

   // Entry 0 is unused; the table is indexed directly by round number.
   localparam logic [7:0] RCON [0:10] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // sub is SubWord(RotWord(w3)) of k, computed by the shared S-box instance.
   function automatic logic [127:0] expand_key(input logic [127:0] k,
                                               input logic [WORD_W-1:0] sub,
                                               input logic [7:0] rc);
      logic [WORD_W-1:0] t, w0, w1, w2, w3;
      t  = sub ^ {rc, 24'h0};
      w0 = k[127:96] ^ t;
      w1 = k[95:64]  ^ w0;
      w2 = k[63:32]  ^ w1;
      w3 = k[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_128_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_128_sub_word
   import aes_128_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   output logic [WORD_W-1:0] o_word
);

   for (genvar gi = 0; gi < WORD_W / 8; gi++) begin : g_sbox
      assign o_word[gi*8 +: 8] = SBOX[i_word[gi*8 +: 8]];
   end

endmodule

// File: rtl/aes_128_key_sched.sv
// AES-128 round-key generator, one key per key_ready strobe, wrapping after round 10.
// Define AES_KEY_SCHED_CACHE_EN to precompute all round keys into an 11-entry array after each load.
module aes_128_key_sched
   import aes_128_pkg::*;
(
   input  logic         clk,
   input  logic         kill_n,
   input  logic [127:0] key_in,
   input  logic         key_load,
   input  logic         key_ready,
   output logic [127:0] key_round,
   output logic [3:0]   key_round_num,
   output logic         key_valid,
   output logic         key_busy
);

   logic [127:0] r_round;
   logic [3:0]   r_num;
   logic         r_valid;

   logic [WORD_W-1:0] w_sub_in;
   logic [WORD_W-1:0] w_sub_out;
   logic [127:0]      w_expanded;
   logic [3:0]        w_next_num;
   logic              w_step;

   // A load in the same cycle always overrides a step.
   assign w_step     = key_ready && r_valid && !key_load;
   assign w_next_num = (r_num == NR) ? 4'd0 : r_num + 4'd1;

   aes_128_sub_word u_sub_word (
      .i_word (w_sub_in),
      .o_word (w_sub_out)
   );

`ifdef AES_KEY_SCHED_CACHE_EN

   logic [127:0] r_cache [0:10];
   logic [127:0] r_pc_key;
   logic [3:0]   r_pc_idx;
   logic         r_busy;

   assign w_sub_in   = rot_word(r_pc_key[WORD_W-1:0]);
   assign w_expanded = expand_key(r_pc_key, w_sub_out, RCON[r_pc_idx]);

   always_ff @(posedge clk) begin
      if (key_load) begin
         r_cache[0] <= key_in;
      end else if (r_busy) begin
         r_cache[r_pc_idx] <= w_expanded;
      end
   end

   always_ff @(posedge clk or negedge kill_n) begin
      if (!kill_n) begin
         r_round  <= '0;
         r_num    <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_pc_key <= '0;
         r_pc_idx <= '0;
      end else if (key_load) begin
         r_round  <= key_in;
         r_num    <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b1;
         r_pc_key <= key_in;
         r_pc_idx <= 4'd1;
      end else if (r_busy) begin
         r_pc_key <= w_expanded;
         r_pc_idx <= r_pc_idx + 4'd1;
         // r_round still holds round 0 from the load, so only validity flips.
         if (r_pc_idx == NR) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
         end
      end else if (w_step) begin
         r_num   <= w_next_num;
         r_round <= r_cache[w_next_num];
      end
   end

   assign key_busy = r_busy;

`else

   logic [127:0] r_key;

   assign w_sub_in   = rot_word(r_round[WORD_W-1:0]);
   assign w_expanded = expand_key(r_round, w_sub_out, RCON[w_next_num]);

   always_ff @(posedge clk or negedge kill_n) begin
      if (!kill_n) begin
         r_key   <= '0;
         r_round <= '0;
         r_num   <= '0;
         r_valid <= 1'b0;
      end else if (key_load) begin
         r_key   <= key_in;
         r_round <= key_in;
         r_num   <= '0;
         r_valid <= 1'b1;
      end else if (w_step) begin
         r_num   <= w_next_num;
         r_round <= (r_num == NR) ? r_key : w_expanded;
      end
   end

   assign key_busy = 1'b0;

`endif

   assign key_round     = r_round;
   assign key_round_num = r_num;
   assign key_valid     = r_valid;

endmodule

// File: tb/tb_aes_128_key_sched.sv
// Directed-vector bench for aes_128_key_sched using FIPS-197 key-expansion vectors;
// covers AES_KEY_SCHED_CACHE_EN builds as well.
module tb_aes_128_key_sched;

   logic         clk;
   logic         kill_n;
   logic [127:0] key_in;
   logic         key_load;
   logic         key_ready;
   logic [127:0] key_round;
   logic [3:0]   key_round_num;
   logic         key_valid;
   logic         key_busy;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_A1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] KEY_A2 = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] KEY_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_B1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

   aes_128_key_sched dut (
      .clk           (clk),
      .kill_n        (kill_n),
      .key_in        (key_in),
      .key_load      (key_load),
      .key_ready     (key_ready),
      .key_round     (key_round),
      .key_round_num (key_round_num),
      .key_valid     (key_valid),
      .key_busy      (key_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end else begin
         $display("[TB] ok   %s = %h", tag, act);
      end
   endtask

   task automatic do_load(input logic [127:0] k, input logic with_ready);
      @(negedge clk);
      key_in    = k;
      key_load  = 1'b1;
      key_ready = with_ready;
      @(negedge clk);
      key_load  = 1'b0;
      key_ready = 1'b0;
   endtask

   // Step and leave two idle cycles, matching the consumer's 3-cycle round.
   task automatic do_step();
      @(negedge clk);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic settle();
`ifdef AES_KEY_SCHED_CACHE_EN
      int g;
      g = 0;
      while (!key_valid && g < 40) begin
         @(negedge clk);
         g++;
      end
      check("settle_valid", {127'd0, key_valid}, 128'd1);
`endif
   endtask

   initial begin
      kill_n    = 1'b0;
      key_in    = '0;
      key_load  = 1'b0;
      key_ready = 1'b0;
      #12;
      check("rst_round", key_round, 128'd0);
      check("rst_num",   {124'd0, key_round_num}, 128'd0);
      check("rst_valid", {127'd0, key_valid}, 128'd0);
      check("rst_busy",  {127'd0, key_busy}, 128'd0);
      @(negedge clk);
      kill_n = 1'b1;

      do_step();
      check("noload_valid", {127'd0, key_valid}, 128'd0);
      check("noload_round", key_round, 128'd0);
      check("noload_num",   {124'd0, key_round_num}, 128'd0);

      do_load(KEY_A, 1'b0);
`ifdef AES_KEY_SCHED_CACHE_EN
      begin
         int n_busy;
         check("cache_busy_t1",  {127'd0, key_busy}, 128'd1);
         check("cache_valid_t1", {127'd0, key_valid}, 128'd0);
         key_ready = 1'b1;
         @(negedge clk);
         key_ready = 1'b0;
         n_busy = 1;
         while (key_busy && n_busy < 30) begin
            n_busy++;
            @(negedge clk);
         end
         check("cache_busy_cycles", 128'(n_busy), 128'd10);
      end
`endif
      check("load_round", key_round, KEY_A);
      check("load_num",   {124'd0, key_round_num}, 128'd0);
      check("load_valid", {127'd0, key_valid}, 128'd1);

      do_step();
      check("step1_round", key_round, KEY_A1);
      check("step1_num",   {124'd0, key_round_num}, 128'd1);
      do_step();
      check("step2_round", key_round, KEY_A2);
      for (int i = 3; i <= 10; i++) do_step();
      check("step10_round", key_round, KEY_A10);
      check("step10_num",   {124'd0, key_round_num}, 128'd10);
      do_step();
      check("wrap_round", key_round, KEY_A);
      check("wrap_num",   {124'd0, key_round_num}, 128'd0);
      do_step();
      check("wrap_step1_round", key_round, KEY_A1);

      do_load(KEY_B, 1'b1);
      settle();
      check("ld_rdy_round", key_round, KEY_B);
      check("ld_rdy_num",   {124'd0, key_round_num}, 128'd0);

      do_load(KEY_A, 1'b0);
      settle();
      for (int i = 0; i < 5; i++) do_step();
      check("mid_num5", {124'd0, key_round_num}, 128'd5);
      do_load(KEY_B, 1'b0);
      settle();
      check("reload_round", key_round, KEY_B);
      check("reload_num",   {124'd0, key_round_num}, 128'd0);
      do_step();
      check("reload_step1_round", key_round, KEY_B1);
      check("reload_step1_num",   {124'd0, key_round_num}, 128'd1);

      do_load(KEY_A, 1'b0);
      settle();
      for (int i = 0; i < 7; i++) do_step();
      check("kill_pre_num", {124'd0, key_round_num}, 128'd7);
      #2;
      kill_n = 1'b0;
      #1;
      check("kill_round", key_round, 128'd0);
      check("kill_num",   {124'd0, key_round_num}, 128'd0);
      check("kill_valid", {127'd0, key_valid}, 128'd0);
      @(negedge clk);
      kill_n = 1'b1;
      do_step();
      check("post_kill_valid", {127'd0, key_valid}, 128'd0);
      check("post_kill_round", key_round, 128'd0);
      check("post_kill_num",   {124'd0, key_round_num}, 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_128_key_sched.md
Name: aes_128_key_sched

Overview:
- Round-key generator directly upstream of the AES-128 encryption top.
- Latches a 128-bit cipher key and produces round keys 0..10 on `key_round`, one per step.
- Steps once on each `key_ready` pulse from the consumer's control logic, then wraps to round 0 for the next block.
- Computes keys on the fly with the FIPS-197 expansion: RotWord, SubWord, Rcon.

Parameters:
- NR, 10, number of rounds; last round index; fixed for AES-128, not overridable in practice.

Ports:
- clk  input  1  system clock, all state on rising edge.
- kill_n  input  1  asynchronous active-low reset.
- key_in  input  128  cipher key, byte 0 in [127:120].
- key_load  input  1  single-cycle strobe: capture key_in, restart at round 0.
- key_ready  input  1  single-cycle strobe from consumer: advance to next round key.
- key_round  output  128  current round key, registered.
- key_round_num  output  4  index of key on key_round, 0..10.
- key_valid  output  1  key_round holds a valid key for the loaded cipher key.
- key_busy  output  1  precompute in progress (optional feature only; else tied 0).

Behaviour:
- Reset (kill_n low, async): key_round=0, key_round_num=0, key_valid=0, key_busy=0, stored key=0. Reset mid-sequence abandons the sequence; a new key_load is required.
- key_load in cycle t:
  - Stored key <= key_in.
  - In t+1: key_round=key_in, key_round_num=0, key_valid=1.
- key_ready in cycle t, key_valid=1, key_round_num=r<10:
  - In t+1: key_round=expand(key_round, rcon[r+1]), key_round_num=r+1.
- key_ready with r=10: in t+1, key_round=stored key, key_round_num=0. This wrap is back-to-back-block behaviour.
- key_ready while key_valid=0: ignored, no state change.
- key_load and key_ready in the same cycle: key_load wins; key_ready is dropped.
- key_load mid-sequence: immediate restart at round 0 with the new key; no residue from the old key.
- Without key_ready and key_load, all outputs hold.
- Latency is 1 cycle from strobe to new key, well inside the 3-cycle round of the consumer.
- expand(w0..w3, rc), words big-endian:
  - t = SubWord(RotWord(w3)) xor {rc,24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.

Optional Feature:
- Macro: AES_KEY_SCHED_CACHE_EN.
- Defined:
  - An 11-entry x 128-bit key array.
  - After key_load, keys 1..10 are computed one per cycle.
  - key_busy=1 from t+1 for 10 cycles; key_valid=0 while busy; key_valid=1 with round 0 at t+11.
  - key_ready while busy is ignored.
  - Stepping reads array[key_round_num], registered, same 1-cycle latency and wrap rules.
  - key_load while busy restarts the precompute.
- Undefined: on-the-fly expansion only; no array; key_busy tied 0.

Decomposition:
- Package aes_128_pkg holds:
  - Rcon table constant.
  - S-box table constant.
  - Round-count constants NR=10 and NK=4.
  - Word-width constant (32).
- One sub-module, aes_128_sub_word: combinational, 32-bit in/out, four S-box lookups.
  - Instantiated once for on-the-fly mode.
  - Instantiated once, shared across precompute cycles, in cache mode.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_load → next cycle key_round=same, num=0, valid=1; one key_ready → a0fafe1788542cb123a339392a6c7605, num=1.
- Same key, 10 key_ready pulses spaced 3 cycles → round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, num=10; 11th pulse → 2b7e1516..., num=0.
- key_ready with no prior load → key_valid stays 0, key_round stays 0; key_load+key_ready in the same cycle → num=0, key=key_in.
- Load key A, step to num=5, load key 000102030405060708090a0b0c0d0e0f → num=0; one step → d6aa74fdd2af72fadaa678f1d6ab76fe.
- kill_n low mid-sequence (num=7) → all outputs 0 asynchronously; after release, key_ready ignored until key_load.
- AES_KEY_SCHED_CACHE_EN: FIPS key load → busy high 10 cycles, valid at t+11; key_ready during busy ignored; stepped sequence matches on-the-fly vectors.
